// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: 32-bit restoring divide sequencer, one quotient bit per clock,
// signed via magnitude conversion and sign fix-up, with divide-by-zero flag.
module div_seq_ctrl (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    logic [2:0]  r_state;
    logic [4:0]  r_cnt;
    logic        r_sop;
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [32:0] r_a;
    logic [31:0] r_q;
    logic [31:0] r_m;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic        r_dbz;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [32:0] w_a_sh;
    logic [32:0] w_trial;
    always_comb begin
        w_dvd_mag = (r_sop && r_dvd[31]) ? -r_dvd : r_dvd;
        w_dvs_mag = (r_sop && r_dvs[31]) ? -r_dvs : r_dvs;
        w_a_sh    = {r_a[31:0], r_q[31]};
        w_trial   = w_a_sh - {1'b0, r_m};
    end
    // Partial remainder is 33 bits so divisors >= 2^31 still restore correctly
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sop   <= 1'b0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_dvd   <= dividend;
                    r_dvs   <= divisor;
                    r_sop   <= signed_op;
                    r_state <= S_PREP;
                end
                S_PREP: if (r_dvs == '0) begin
                    r_quot  <= '1;
                    r_rem   <= r_dvd;
                    r_dbz   <= 1'b1;
                    r_state <= S_DONE;
                end else begin
                    r_a     <= '0;
                    r_q     <= w_dvd_mag;
                    r_m     <= w_dvs_mag;
                    r_neg_q <= r_sop & (r_dvd[31] ^ r_dvs[31]);
                    r_neg_r <= r_sop & r_dvd[31];
                    r_cnt   <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_a     <= w_trial[32] ? w_a_sh : w_trial;
                    r_q     <= {r_q[30:0], ~w_trial[32]};
                    r_cnt   <= r_cnt + 5'd1;
                    r_state <= (r_cnt == 5'd31) ? S_FIX : S_ITER;
                end
                S_FIX: begin
                    r_quot  <= r_neg_q ? -r_q : r_q;
                    r_rem   <= r_neg_r ? -r_a[31:0] : r_a[31:0];
                    r_dbz   <= 1'b0;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed vectors; expected results queued at start, popped
// and compared by a monitor whenever done is seen.
module tb_div_seq_ctrl;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;
    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    div_seq_ctrl dut (
        .clk(clk), .clr(clr), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );
    always #5 clk = ~clk;
    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
            end
        end
    end
    task automatic run(input string nm, input logic sop, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez,
                       input int inj, input logic [31:0] ia, input logic [31:0] ib);
        int k;
        int d0;
        exp_t e;
        @(negedge clk);
        signed_op = sop;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        e.q = eq;
        e.r = er;
        e.z = ez;
        sb.push_back(e);
        d0 = n_done;
        #1;
        start = 1'b0;
        dividend = ~a;
        divisor = b + 32'd1;
        signed_op = ~sop;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            start = (k == inj);
            if (k == inj) begin
                dividend = ia;
                divisor = ib;
            end
            if (k == 1) chk({nm, " busy"}, {31'd0, busy}, 32'd1);
        end while (done !== 1'b1 && k < 100);
        chk({nm, " latency"}, k, ez ? 32'd2 : 32'd35);
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy after"}, {31'd0, busy}, 32'd0);
        chk({nm, " done pulses"}, n_done - d0, 32'd1);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
        clr = 1'b0;
        run("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, 0, 0);
        run("uFFFFFFFF/80000000", 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 0, 0, 0);
        run("uFFFFFFFF/1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 0, 0, 0);
        run("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0, 0, 0);
        run("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 0, 0, 0);
        run("s-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 0, 0, 0);
        run("s80000000/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 0, 0, 0);
        run("u5/0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 0, 0, 0);
        run("s5/0", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 0, 0, 0);
        run("u9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0, 0, 0);
        run("ign busy start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10, 32'd50, 32'd5);
        run("ign done start", 1'b0, 32'd20, 32'd4, 32'd5, 32'd0, 1'b0, 35, 32'd50, 32'd5);
        begin
            int d0;
            @(negedge clk);
            signed_op = 1'b0;
            dividend = 32'd100;
            divisor = 32'd7;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (13) @(negedge clk);
            d0 = n_done;
            clr = 1'b1;
            #1;
            chk("clr busy", {31'd0, busy}, 32'd0);
            chk("clr done", {31'd0, done}, 32'd0);
            chk("clr quotient", quotient, 32'd0);
            chk("clr remainder", remainder, 32'd0);
            @(negedge clk);
            clr = 1'b0;
            repeat (40) @(negedge clk);
            chk("clr no done", n_done - d0, 32'd0);
        end
        run("u20/3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 0, 0, 0);
        chk("scoreboard empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Multi-cycle sequencer for the restoring divide datapath, used by the ALU for DIV instructions. Latches a 32-bit dividend and divisor on a start request and runs one restoring-division step per clock for 32 cycles. Handles signed operands by magnitude conversion and sign fix-up, and flags divide-by-zero. Returns quotient (LO) and remainder (HI) with a one-cycle done pulse.

## Interface
- No parameters; width fixed at 32 bits.
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned; latched with start.
- dividend  input  32  latched on accepted start.
- divisor  input  32  latched on accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, high only in DONE.
- quotient  output  32  result for LO.
- remainder  output  32  result for HI.
- div_by_zero  output  1  set with the result when the latched divisor was 0.

## Operation
- Reset values: all outputs 0, state IDLE, iteration counter 0, internal registers 0.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: when start=1, latch operands and signed_op, then go to PREP. When start=0, stay in IDLE.
- PREP:
  - If divisor==0, load quotient=32'hFFFFFFFF, remainder=latched dividend and div_by_zero=1, then go to DONE.
  - Otherwise, compute magnitudes: for a signed op with a negative operand, take the two's complement; otherwise use the operand as-is.
  - Record neg_q = signed_op & (sign(dividend) ^ sign(divisor)) and neg_r = signed_op & sign(dividend).
  - Clear the 33-bit partial remainder A, load Q = |dividend|, set counter=0, go to ITER.
- ITER (exactly 32 cycles, counter 0..31):
  - Shift {A,Q} left by one.
  - Compute trial = A - {1'b0,|divisor|} in 33 bits.
  - If trial[32]=0, set A=trial and Q[0]=1. Otherwise keep A (restore) and set Q[0]=0.
  - After counter 31, go to FIX.
- Width rule: A is 33 bits, so unsigned divisors ≥ 2^31 divide correctly. A 32-bit sign test on the partial remainder is not acceptable.
- FIX:
  - quotient = neg_q ? -Q : Q.
  - remainder = neg_r ? -A[31:0] : A[31:0].
  - div_by_zero = 0.
  - Go to DONE.
- Signed semantics: truncation toward zero; the remainder takes the sign of the dividend.
- Overflow case: 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000, remainder 0, with no flag.
- DONE: done=1 for this one cycle, then go to IDLE.
- quotient, remainder and div_by_zero hold their values until the next FIX, PREP-zero load, or clr.
- start while busy=1 is ignored; it is not queued and does not disturb the operands.
- clr mid-operation: immediate return to IDLE with all outputs 0. No partial result is visible and done does not pulse.
- Operand inputs may change freely after the start edge without affecting the result.

## Timing
- Edge E0 is the first clock edge on which start=1 is seen in IDLE.
- Normal path:
  - PREP after E0, ITER after E1, ITER steps on E2..E33, FIX after E33, DONE after E34, IDLE after E35.
  - done is high between E34 and E35, 35 cycles of latency.
  - Results are valid from E34 onward.
- Divide-by-zero path: PREP after E0, DONE after E1, done high between E1 and E2, IDLE after E2.
- busy rises after E0 and falls after the edge that leaves DONE.
- Back-to-back operation: start held high during DONE is ignored. A start in the first IDLE cycle after DONE is accepted, so the minimum spacing between accepted starts is 36 cycles.
- No combinational path from any input to any output.

## Test plan
- Unsigned 100 / 7, start pulsed at E0 -> done at E34, quotient=14, remainder=2, div_by_zero=0, busy high E0..E35.
- Unsigned 0xFFFFFFFF / 0x80000000 -> quotient=1, remainder=0x7FFFFFFF; this checks the 33-bit partial-remainder rule.
- Signed -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / -2 -> quotient=0xFFFFFFFD, remainder=1. Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- 5 / 0, either signedness -> done at E1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. A following 9 / 3 clears the flag: quotient=3, remainder=0, div_by_zero=0.
- Start 100 / 7, then pulse start with 50 / 5 at E10 -> second request ignored, result 14 / 2 at E34, exactly one done pulse.
- Start 100 / 7, assert clr between E12 and E13 -> outputs and busy go to 0 immediately with no done pulse. A new start of 20 / 3 then yields quotient=6, remainder=2 after 35 cycles.
